// File: rtl/bcd_clock_pkg.sv
// bcd_clock_pkg
//   Shared constants for the 12-hour BCD clock and its display scanner:
//   active-low 7-segment glyphs (a..g on bit0..bit6), digit slot indices
//   for the six-digit display, and the clock's reset-time values (the
//   scanner's shadow registers reset to the same time so the first frame
//   matches the clock).
package bcd_clock_pkg;

    // Active-low glyphs: bit clear = segment lit.
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;  // only g lit
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Digit slots, rightmost (seconds ones) first.
    localparam logic [2:0] DIG_SS_L = 3'd0;
    localparam logic [2:0] DIG_SS_H = 3'd1;
    localparam logic [2:0] DIG_MM_L = 3'd2;
    localparam logic [2:0] DIG_MM_H = 3'd3;
    localparam logic [2:0] DIG_HH_L = 3'd4;
    localparam logic [2:0] DIG_HH_H = 3'd5;

    // Clock reset time: 01:00:00 PM.
    localparam logic [7:0] RST_HH = 8'h01;
    localparam logic [7:0] RST_MM = 8'h00;
    localparam logic [7:0] RST_SS = 8'h00;
    localparam logic       RST_PM = 1'b1;

    // BCD nibble to glyph; anything above 9 renders as a dash.
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational BCD nibble to active-low 7-segment decoder.
//   Ports:
//     nib        in  4  BCD digit; values above 9 show a dash
//     blank_zero in  1  when set, a zero nibble renders as all-off
//     seg        out 7  segments a..g on bit0..bit6, active-low
module bcd_to_seg7
    import bcd_clock_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank_zero,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_glyph(nib);
        if (blank_zero && (nib == 4'd0))
            seg = SEG_OFF;
    end

endmodule

// File: rtl/bcd_clock_display_scan.sv
// bcd_clock_display_scan
//   Six-digit time-multiplexed common-anode display driver for the 12-hour
//   BCD clock. A prescaler divides clk into SCAN_DIV-cycle digit slots; the
//   first BLANK_CYC cycles of each slot keep all anodes off to avoid
//   ghosting. The time is snapshotted into shadow registers at the end of
//   digit 5 so every frame shows one consistent time.
//   Parameters:
//     SCAN_DIV   clk cycles per digit slot (>= 4)
//     BLANK_CYC  leading cycles of a slot with anodes off (< SCAN_DIV)
//   Ports:
//     clk    in  1  clock, rising edge
//     reset  in  1  asynchronous, active-low
//     pm     in  1  PM flag (lights the dot on digit 0)
//     hh     in  8  hours BCD
//     mm     in  8  minutes BCD
//     ss     in  8  seconds BCD
//     blank  in  1  forces all anodes off; counters keep running
//     seg    out 7  segments a..g, active-low, registered
//     dp     out 1  decimal point, active-low, registered
//     an     out 6  anodes, active-low, bit k = digit k, registered
module bcd_clock_display_scan
    import bcd_clock_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] TC_V    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);

    logic [CW-1:0] div_cnt;
    logic [2:0]    dig;
    logic          tc;
    logic          frame_start;

    logic [7:0]    sh_hh, sh_mm, sh_ss;
    logic          sh_pm;

    logic [3:0]    nib;
    logic          blz;
    logic          dot;
    logic [6:0]    seg_d;
    logic [5:0]    an_d;

    assign tc          = (div_cnt == TC_V);
    assign frame_start = tc && (dig == DIG_HH_H);

    // Prescaler and digit counter; blank never touches these.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            dig     <= DIG_SS_L;
        end else if (tc) begin
            div_cnt <= '0;
            dig     <= (dig == DIG_HH_H) ? DIG_SS_L : dig + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Snapshot on the last cycle of digit 5: the digit-5 output of that
    // cycle still comes from the old shadow, digit 0 onward uses the new one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_hh <= RST_HH;
            sh_mm <= RST_MM;
            sh_ss <= RST_SS;
            sh_pm <= RST_PM;
        end else if (frame_start) begin
            sh_hh <= hh;
            sh_mm <= mm;
            sh_ss <= ss;
            sh_pm <= pm;
        end
    end

    // Digit mux. Unreachable indices 6/7 map to a blanked zero.
    always_comb begin
        nib = 4'h0;
        blz = 1'b0;
        dot = 1'b0;
        case (dig)
            DIG_SS_L: begin nib = sh_ss[3:0]; dot = sh_pm; end
            DIG_SS_H: nib = sh_ss[7:4];
            DIG_MM_L: begin nib = sh_mm[3:0]; dot = 1'b1;  end
            DIG_MM_H: nib = sh_mm[7:4];
            DIG_HH_L: begin nib = sh_hh[3:0]; dot = 1'b1;  end
            DIG_HH_H: begin nib = sh_hh[7:4]; blz = 1'b1;  end
            default:  blz = 1'b1;
        endcase
    end

    bcd_to_seg7 u_dec (
        .nib        (nib),
        .blank_zero (blz),
        .seg        (seg_d)
    );

    // One-hot-low anode for the current digit, gated by the ghost-blank
    // window and the blank input. A shift past bit 5 yields all-off.
    always_comb begin
        an_d = 6'h3F;
        if ((div_cnt >= BLANK_V) && !blank)
            an_d = ~(6'b000001 << dig);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
            an  <= 6'h3F;
        end else begin
            seg <= seg_d;
            dp  <= ~dot;
            an  <= an_d;
        end
    end

endmodule

// File: doc/bcd_clock_display_scan.md
# bcd_clock_display_scan

Downstream consumer of the 12-hour BCD clock. Takes the clock's `hh`/`mm`/`ss`/`pm` outputs and drives a six-digit, time-multiplexed, common-anode 7-segment display. Scanning is continuous. Time values are snapshotted once per scan frame so that no frame mixes old and new digits. The block also applies leading-zero blanking, separator dots, a PM indicator and an anti-ghosting blank interval.

## Interface
- `SCAN_DIV`, default 1000: clk cycles per digit slot; must be ≥ 4.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `pm` in 1: PM flag from the clock.
- `hh` in 8: hours BCD, valid 01–12.
- `mm` in 8: minutes BCD.
- `ss` in 8: seconds BCD.
- `blank` in 1: display off while high; scanning continues.
- `seg` out 7: segments a..g at bit0..bit6, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 6: digit anodes, active-low; bit k selects digit k.

## Operation
- Prescaler `div_cnt`, width clog2(`SCAN_DIV`), counts 0..`SCAN_DIV`-1 and wraps. Terminal count is `tc`.
- Digit index `dig` (3 bits) advances on `tc`: 0→1→…→5→0. Values 6 and 7 are unreachable.
- Digit map:
  - 0 = `ss[3:0]`
  - 1 = `ss[7:4]`
  - 2 = `mm[3:0]`
  - 3 = `mm[7:4]`
  - 4 = `hh[3:0]`
  - 5 = `hh[7:4]`
- Shadow registers `sh_hh/sh_mm/sh_ss/sh_pm` load from the inputs on the cycle where `tc` and `dig`==5 (frame start). Every digit of a frame comes from the shadows.
- Per-digit decode, from the shadowed nibble:
  - 0–9: standard 7-seg glyph.
  - Nibble > 9: `-` (only g lit).
  - Digit 5 with nibble 0: blank (all segments off; leading-zero suppression).
- Dot, active when lit:
  - On digits 2 and 4 always (separators).
  - On digit 0 iff `sh_pm`=1.
  - Off otherwise.
- Anode enable: `an[dig]` active iff `div_cnt` ≥ `BLANK_CYC` and `blank`=0. All other anodes are always inactive.
- No FSM beyond the `div_cnt`/`dig` counter pair. `blank` does not reset or pause the counters.

## Timing
- Reset values (asynchronous, held while `reset`=0):
  - `div_cnt`=0, `dig`=0.
  - `sh_hh`=8'h01, `sh_mm`=8'h00, `sh_ss`=8'h00, `sh_pm`=1 (matches clock reset state).
  - `seg`=7'h7F, `dp`=1, `an`=6'h3F (all off).
- `seg`/`dp`/`an` are registered: they reflect the `div_cnt`/`dig`/shadow/`blank` state of the previous cycle. Latency is 1 cycle.
- Slot length is exactly `SCAN_DIV` cycles. The lit portion is `SCAN_DIV`-`BLANK_CYC` cycles. Frame length is 6·`SCAN_DIV`.
- The first frame after reset release displays the shadow reset values. Live inputs first appear after the first 5→0 wrap, i.e. 6·`SCAN_DIV` cycles after release (+1 output latency).
- Input change mid-frame is not shown until the next frame start. Input change on the capture cycle itself is captured.
- Reset asserted mid-slot forces outputs off immediately. Scanning restarts at digit 0, count 0.
- `blank` rising/falling takes effect on `an` one cycle later. `seg`/`dp` keep decoding.
- At most one `an` bit is active on any cycle. No anode is active during the first `BLANK_CYC`+1 output cycles of a slot.

## Structure
- Shared package `bcd_clock_pkg`, holding:
  - The 7-seg glyph constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF` (active-low encodings).
  - The digit index constants `DIG_SS_L`..`DIG_HH_H`.
  - The reset-time constants `RST_HH/RST_MM/RST_SS/RST_PM`, shared with the clock block.
- One combinational sub-module, `bcd_to_seg7`: 4-bit nibble plus `blank_zero` enable in, 7-bit active-low pattern out.
- Top level holds the prescaler, digit counter, shadows, mux and output registers.

## Test plan
Run all with `SCAN_DIV`=8, `BLANK_CYC`=2.
- **Reset:** release reset, inputs 11:59:58 AM (`pm`=0) → first frame shows 01:00:00, dp on digit 0 (PM). Second frame shows 11:59:58, digit 0 dp off, digits 2/4 dp on.
- **Scan timing:** free run → each `an` bit is low for exactly 6 of every 8 cycles, in order 0..5. Frame period is 48 cycles. `an` is never multi-hot.
- **Leading zero / invalid BCD:** `hh`=8'h09 → digit 5 all segments off. `hh`=8'h1A → digit 4 shows `-` (seg=7'h3F).
- **Tear-free capture:** change `ss` from 8'h59 to 8'h00 mid-frame (during digit 2) → rest of the frame still shows 59. The next frame shows 00. Also change the inputs on the exact capture cycle → the new value is displayed in the next frame.
- **Blank:** assert `blank` for 20 cycles → `an`=6'h3F from the next cycle. After release, scanning resumes at the slot implied by the uninterrupted count.
- **Async reset mid-slot:** drop `reset` at `dig`=3, `div_cnt`=5 between clock edges → outputs go all-off with no clock edge. After release, the digit 0 slot starts at `div_cnt`=0.
